// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types and constants for the paddle button conditioner
// Purpose: repeat-FSM state type, button index map and default timing constants.
// Ports: none (package).
package paddle_pkg;

    // Per-channel hold-to-repeat states: released, waiting for first repeat, repeating.
    typedef enum logic [1:0] {
        REL   = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rep_state_t;

    // Bit positions inside the button vector {p2b2, p2b1, p1b2, p1b1}.
    localparam int unsigned IDX_P1_UP = 0;
    localparam int unsigned IDX_P1_DN = 1;
    localparam int unsigned IDX_P2_UP = 2;
    localparam int unsigned IDX_P2_DN = 3;

    // Defaults for a 100 MHz sysclk.
    localparam int unsigned DEF_NUM_BTN       = 4;
    localparam int unsigned DEF_DB_CYCLES     = 1000000;   // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY  = 40000000;  // 400 ms
    localparam int unsigned DEF_REPEAT_PERIOD = 10000000;  // 100 ms
    localparam int unsigned DEF_CNT_W         = 28;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debouncer, press strobe, optional repeat
// Purpose: conditions a single asynchronous push-button into sysclk-domain level/strobes.
// Build option: PADDLE_REPEAT_EN adds the hold-to-repeat FSM; without it o_step == o_press.
// Ports:
//   i_clk    - sysclk
//   i_rst_n  - synchronous active-low reset
//   i_raw    - asynchronous active-high button pin
//   o_level  - debounced level
//   o_press  - one-cycle strobe on each debounced rising edge
//   o_step   - one-cycle strobe: press OR repeat
module btn_channel
    import paddle_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_step
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_step;
    logic [CNT_W-1:0] r_db_cnt;

    logic w_differ;
    logic w_toggle;
    logic w_level_nxt;
    logic w_press_nxt;
    logic w_rep_strobe;

    assign w_differ    = (r_sync2 != r_level);
    assign w_toggle    = w_differ && (r_db_cnt == DB_LAST);
    assign w_level_nxt = w_toggle ? ~r_level : r_level;
    // Strobes are decided from the next level so they register on the same edge as the level.
    assign w_press_nxt = w_toggle && !r_level;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_press  <= 1'b0;
            r_step   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // One cycle of agreement wipes all debounce progress.
            if (!w_differ || w_toggle) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
            r_level <= w_level_nxt;
            r_press <= w_press_nxt;
            r_step  <= w_press_nxt | w_rep_strobe;
        end
    end

`ifdef PADDLE_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_t       r_state;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             w_rep_due;

    assign w_rep_due = ((r_state == DELAY) && (r_rep_cnt == RD_LAST)) ||
                       ((r_state == RPT)   && (r_rep_cnt == RP_LAST));
    // A release landing on the same edge as a due repeat wins: no strobe.
    assign w_rep_strobe = w_rep_due && w_level_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= REL;
            r_rep_cnt <= '0;
        end else if (!w_level_nxt) begin
            r_state   <= REL;
            r_rep_cnt <= '0;
        end else begin
            unique case (r_state)
                REL: begin
                    r_rep_cnt <= '0;
                    if (w_press_nxt) begin
                        r_state <= DELAY;
                    end
                end
                DELAY: begin
                    if (r_rep_cnt == RD_LAST) begin
                        r_rep_cnt <= '0;
                        r_state   <= RPT;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                    end
                end
                RPT: begin
                    if (r_rep_cnt == RP_LAST) begin
                        r_rep_cnt <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= REL;
                    r_rep_cnt <= '0;
                end
            endcase
        end
    end
`else
    // Repeat timing is accepted but has no effect in this build.
    logic w_unused_rep;
    assign w_unused_rep = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
    assign w_rep_strobe = 1'b0;
`endif

    assign o_level = r_level;
    assign o_press = r_press;
    assign o_step  = r_step;

endmodule

// File: rtl/paddle_input_cond.sv
// rtl/paddle_input_cond.sv - conditions the four paddle push-buttons for the game core
// Purpose: per-channel synchroniser, debouncer, press strobe and optional hold-to-repeat.
// Build option: define PADDLE_REPEAT_EN to include repeat strobes in o_btn_step.
// Ports (bit order {p2b2, p2b1, p1b2, p1b1}):
//   i_sysclk     - single clock
//   i_rst_n      - synchronous active-low reset
//   i_btn_raw    - asynchronous active-high button pins
//   o_btn_level  - debounced levels
//   o_btn_press  - one-cycle strobes on debounced rising edges
//   o_btn_step   - one-cycle strobes, press OR repeat (consumed by paddle logic)
module paddle_input_cond
    import paddle_pkg::*;
#(
    parameter int unsigned NUM_BTN       = DEF_NUM_BTN,
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,     // must be >= 2
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic               i_sysclk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic [NUM_BTN-1:0] o_btn_step
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_chan (
            .i_clk  (i_sysclk),
            .i_rst_n(i_rst_n),
            .i_raw  (i_btn_raw[g]),
            .o_level(o_btn_level[g]),
            .o_press(o_btn_press[g]),
            .o_step (o_btn_step[g])
        );
    end

endmodule

// File: tb/tb_paddle_input_cond.sv
// tb/tb_paddle_input_cond.sv - directed self-checking bench for paddle_input_cond
module tb_paddle_input_cond;
    import paddle_pkg::*;

`ifdef PADDLE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw = 4'b0000;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] step;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    paddle_input_cond #(
        .NUM_BTN      (4),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3),
        .CNT_W        (8)
    ) dut (
        .i_sysclk   (clk),
        .i_rst_n    (rst_n),
        .i_btn_raw  (raw),
        .o_btn_level(level),
        .o_btn_press(press),
        .o_btn_step (step)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        raw   = 4'b0000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // In every test the raw change is applied right after the edge named -1,
    // so "edge e" below is the e-th rising edge after that change.
    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_level", 32'(level), 32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_step",  32'(step),  32'h0);

        // Glitch rejection: 3 cycles high on p1b1
        do_reset();
        raw[IDX_P1_UP] = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            tick();
            check($sformatf("glitch_level@%0d", e), 32'(level), 32'h0);
            check($sformatf("glitch_press@%0d", e), 32'(press), 32'h0);
            check($sformatf("glitch_step@%0d",  e), 32'(step),  32'h0);
            if (e == 2) raw[IDX_P1_UP] = 1'b0;
        end

        // Clean press on p1b2
        do_reset();
        raw[IDX_P1_DN] = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check($sformatf("press_level@%0d", e), 32'(level[IDX_P1_DN]), 32'(e >= 5));
            check($sformatf("press_press@%0d", e), 32'(press[IDX_P1_DN]), 32'(e == 5));
            check($sformatf("press_step@%0d",  e), 32'(step[IDX_P1_DN]),  32'(e == 5));
        end

        // Auto-repeat on p2b1; release after edge 27 lands the fall on edge 33,
        // exactly when the next repeat would be due, so it must be suppressed.
        do_reset();
        raw[IDX_P2_UP] = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            logic rep;
            tick();
            rep = REP_EN && (e == 15 || e == 18 || e == 21 || e == 24 || e == 27 || e == 30);
            check($sformatf("rpt_step@%0d",  e), 32'(step[IDX_P2_UP]),  32'((e == 5) || rep));
            check($sformatf("rpt_level@%0d", e), 32'(level[IDX_P2_UP]), 32'(e >= 5 && e <= 32));
            if (e == 27) raw[IDX_P2_UP] = 1'b0;
        end

        // Release before first repeat on p2b2: raw falls after edge 7
        do_reset();
        raw[IDX_P2_DN] = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            tick();
            check($sformatf("rel_step@%0d",  e), 32'(step[IDX_P2_DN]),  32'(e == 5));
            check($sformatf("rel_level@%0d", e), 32'(level[IDX_P2_DN]), 32'(e >= 5 && e <= 12));
            if (e == 7) raw[IDX_P2_DN] = 1'b0;
        end

        // Simultaneous channels
        do_reset();
        raw = 4'b1111;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check($sformatf("all_press@%0d", e), 32'(press), (e == 5) ? 32'hF : 32'h0);
            check($sformatf("all_step@%0d",  e), 32'(step),  (e == 5) ? 32'hF : 32'h0);
        end

        // Reset mid-hold on p1b1: rst_n low for edge 21 only, button kept held
        do_reset();
        raw[IDX_P1_UP] = 1'b1;
        for (int e = 0; e <= 32; e++) begin
            logic rep;
            tick();
            if (e == 21) begin
                check("midrst_level", 32'(level), 32'h0);
                check("midrst_press", 32'(press), 32'h0);
                check("midrst_step",  32'(step),  32'h0);
            end
            rep = REP_EN && (e == 15 || e == 18);
            check($sformatf("mid_level@%0d", e), 32'(level[IDX_P1_UP]),
                  32'((e >= 5 && e <= 20) || e >= 27));
            check($sformatf("mid_press@%0d", e), 32'(press[IDX_P1_UP]), 32'(e == 5 || e == 27));
            check($sformatf("mid_step@%0d",  e), 32'(step[IDX_P1_UP]),
                  32'(e == 5 || e == 27 || rep));
            if (e == 20) rst_n = 1'b0;
            if (e == 21) rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
